muldiv_unit: RTL and testbench

Multi-cycle RV32M multiply/divide unit, parametrised in operand width, sitting beside the single-cycle execute ALU in the execute stage. It takes M-extension operations from issue over a valid/ready handshake and returns results with the destination tag over a second valid/ready handshake. Multiplies go through a fixed-latency register pipeline. Divides use a radix-2 restoring iteration with early-out for the special cases. Results follow RISC-V semantics exactly (true high product for MULH*, spec-defined divide-by-zero and overflow results).

---
 rtl/rv32_pkg.sv | 32 +++
 rtl/serial_divider.sv | 69 ++++++
 rtl/muldiv_unit.sv | 182 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32 execute-stage types: M-extension opcodes (funct3 encoding)
// and the multiply/divide unit state machine.
package rv32_pkg;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } md_state_e;

    // DIV and REM have funct3[0]==0; the unsigned variants have it set.
    function automatic logic md_is_signed_div(md_op_e op);
        return !op[0];
    endfunction

    function automatic logic md_is_rem(md_op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/serial_divider.sv
// Radix-2 restoring divider on unsigned magnitudes: one quotient bit per
// cycle, done pulses for one cycle after the last iteration.
module serial_divider #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            start,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    localparam int CW = $clog2(XLEN + 1);

    logic [CW-1:0]   count;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] dvs_q;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;

    // Partial remainder stays below the divisor, so XLEN+1 bits always hold it.
    always_comb begin
        shifted = {rem_q, quo_q[XLEN-1]};
        diff    = shifted - {1'b0, dvs_q};
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            count <= '0;
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
        end else begin
            done <= 1'b0;
            if (start && !busy) begin
                quo_q <= dividend;
                rem_q <= '0;
                dvs_q <= divisor;
                count <= CW'(XLEN);
                busy  <= 1'b1;
            end else if (busy) begin
                if (diff[XLEN]) begin
                    rem_q <= shifted[XLEN-1:0];
                    quo_q <= {quo_q[XLEN-2:0], 1'b0};
                end else begin
                    rem_q <= diff[XLEN-1:0];
                    quo_q <= {quo_q[XLEN-2:0], 1'b1};
                end
                count <= count - 1'b1;
                if (count == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: pipelined multiplier, serial divider with
// one-cycle special cases, one operation in flight between two handshakes.
module muldiv_unit
    import rv32_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int MUL_STAGES = 2,
    parameter int TAG_W      = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag
);

    localparam int CW = (MUL_STAGES > 1) ? $clog2(MUL_STAGES) : 1;
    localparam logic [CW-1:0]   MUL_LAST = CW'(MUL_STAGES - 1);
    localparam logic [XLEN-1:0] MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e          state, next_state;
    md_op_e             op_q;
    logic [XLEN-1:0]    rs1_q, rs2_q;
    logic [TAG_W-1:0]   tag_q;
    logic [CW-1:0]      mul_cnt;
    logic               accept;

    logic signed [XLEN:0]     mul_a, mul_b;
    logic signed [2*XLEN+1:0] prod_full;
    logic [2*XLEN-1:0]        mul_src;
    logic                     unused_prod_top;

    logic            signed_div, neg_a, neg_b, div_by_zero, div_ovf, div_special;
    logic [XLEN-1:0] a_mag, b_mag, special_result, div_result;
    logic            div_start, div_busy, div_done;
    logic [XLEN-1:0] div_quo, div_rem;
    logic [XLEN-1:0] done_value;

    assign accept    = (state == ST_IDLE) && in_valid && !flush;
    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign out_tag   = tag_q;

    // One extra bit per operand lets a single signed multiplier cover all four MUL variants.
    always_comb begin
        mul_a     = {(op_q != MD_MULHU) & rs1_q[XLEN-1], rs1_q};
        mul_b     = {((op_q == MD_MUL) || (op_q == MD_MULH)) & rs2_q[XLEN-1], rs2_q};
        prod_full = mul_a * mul_b;
    end

    assign unused_prod_top = ^prod_full[2*XLEN+1:2*XLEN];

    generate
        if (MUL_STAGES == 1) begin : g_no_pipe
            assign mul_src = prod_full[2*XLEN-1:0];
        end else begin : g_pipe
            logic [2*XLEN-1:0] pipe [MUL_STAGES-1];
            always_ff @(posedge clk) begin
                pipe[0] <= prod_full[2*XLEN-1:0];
                for (int i = 1; i < MUL_STAGES - 1; i++) begin
                    pipe[i] <= pipe[i-1];
                end
            end
            assign mul_src = pipe[MUL_STAGES-2];
        end
    endgenerate

    always_comb begin
        signed_div     = md_is_signed_div(op_q);
        neg_a          = signed_div & rs1_q[XLEN-1];
        neg_b          = signed_div & rs2_q[XLEN-1];
        a_mag          = neg_a ? -rs1_q : rs1_q;
        b_mag          = neg_b ? -rs2_q : rs2_q;
        div_by_zero    = (rs2_q == '0);
        div_ovf        = signed_div && (rs1_q == MIN_INT) && (rs2_q == '1);
        div_special    = div_by_zero || div_ovf;
        special_result = '0;
        if (div_by_zero) begin
            special_result = md_is_rem(op_q) ? rs1_q : '1;
        end else if (div_ovf) begin
            special_result = md_is_rem(op_q) ? '0 : MIN_INT;
        end
        if (md_is_rem(op_q)) begin
            div_result = neg_a ? -div_rem : div_rem;
        end else begin
            div_result = (neg_a ^ neg_b) ? -div_quo : div_quo;
        end
    end

    // The first DIV cycle is the only one where the divider is neither busy nor done.
    assign div_start = (state == ST_DIV) && !div_busy && !div_done && !div_special && !flush;

    serial_divider #(.XLEN(XLEN)) u_divider (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush),
        .start     (div_start),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_comb begin
        next_state = state;
        done_value = '0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    next_state = in_op[2] ? ST_DIV : ST_MUL;
                end
            end
            ST_MUL: begin
                done_value = (op_q == MD_MUL) ? mul_src[XLEN-1:0] : mul_src[2*XLEN-1:XLEN];
                if (mul_cnt == MUL_LAST) begin
                    next_state = ST_DONE;
                end
            end
            ST_DIV: begin
                if (div_done) begin
                    done_value = div_result;
                    next_state = ST_DONE;
                end else if (!div_busy && div_special) begin
                    done_value = special_result;
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
        if (flush) begin
            next_state = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q       <= MD_MUL;
            rs1_q      <= '0;
            rs2_q      <= '0;
            tag_q      <= '0;
            mul_cnt    <= '0;
            out_result <= '0;
        end else begin
            if (accept) begin
                op_q    <= md_op_e'(in_op);
                rs1_q   <= in_rs1;
                rs2_q   <= in_rs2;
                tag_q   <= in_tag;
                mul_cnt <= '0;
            end else if (state == ST_MUL) begin
                mul_cnt <= mul_cnt + 1'b1;
            end
            if ((state != ST_DONE) && (next_state == ST_DONE)) begin
                out_result <= done_value;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table, scoreboard queue,
// plus hand-written backpressure, flush and reset sequences.
module tb_muldiv_unit;

    localparam int XLEN       = 32;
    localparam int MUL_STAGES = 2;
    localparam int TAG_W      = 5;

    logic             clk = 1'b0;
    logic             reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [2:0]       in_op;
    logic [XLEN-1:0]  in_rs1, in_rs2, out_result;
    logic [TAG_W-1:0] in_tag, out_tag;

    muldiv_unit #(.XLEN(XLEN), .MUL_STAGES(MUL_STAGES), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  result;
    } sb_entry_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    sb_entry_t sb_q[$];
    vec_t      vecs[$];
    int        n_cmp = 0;
    int        n_fail = 0;
    int        t_acc = 0;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Independent RISC-V reference built on native 64-bit arithmetic.
    function automatic logic [31:0] refModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint s1, s2, u1, u2, p;
        logic   ovf;
        s1  = longint'($signed(a));
        s2  = longint'($signed(b));
        u1  = longint'({32'b0, a});
        u2  = longint'({32'b0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = 0;
        case (op)
            3'd0: begin p = s1 * s2; return p[31:0];  end
            3'd1: begin p = s1 * s2; return p[63:32]; end
            3'd2: begin p = s1 * u2; return p[63:32]; end
            3'd3: begin p = u1 * u2; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                p = s1 / s2;
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = u1 / u2;
            end
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                p = s1 % s2;
            end
            default: begin
                if (b == 0) return a;
                p = u1 % u2;
            end
        endcase
        return p[31:0];
    endfunction

    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [TAG_W-1:0] tag, input logic [31:0] exp, input bit push);
        int w;
        in_op    = op;
        in_rs1   = a;
        in_rs2   = b;
        in_tag   = tag;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 100) begin
            step();
            w++;
        end
        checkVal("in_ready_before_accept", {31'b0, in_ready}, 32'd1);
        step();
        t_acc    = cyc;
        in_valid = 1'b0;
        if (push) sb_q.push_back('{tag, exp});
    endtask

    task automatic checkOutput(input string name, input int exp_lat);
        int        w;
        sb_entry_t e;
        w = 0;
        while (!out_valid && w < 100) begin
            step();
            w++;
        end
        checkVal({name, "_out_valid"}, {31'b0, out_valid}, 32'd1);
        if (!out_valid) return;
        if (exp_lat >= 0) checkVal({name, "_latency"}, cyc - t_acc, exp_lat);
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL %s_scoreboard: got result %h with no pending entry, expected none", name, out_result);
        end else begin
            e = sb_q.pop_front();
            checkVal({name, "_result"}, out_result, e.result);
            checkVal({name, "_tag"}, {27'b0, out_tag}, {27'b0, e.tag});
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checkVal({name, "_in_ready_after"}, {31'b0, in_ready}, 32'd1);
        checkVal({name, "_valid_dropped"}, {31'b0, out_valid}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb, rexp;
        int          rlat, w;
        bit          seen;

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_op = '0; in_rs1 = '0; in_rs2 = '0; in_tag = '0;
        step(); step();
        checkVal("reset_in_ready",   {31'b0, in_ready},  32'd1);
        checkVal("reset_out_valid",  {31'b0, out_valid}, 32'd0);
        checkVal("reset_out_result", out_result, 32'd0);
        checkVal("reset_out_tag",    {27'b0, out_tag},   32'd0);
        reset = 1'b0;
        step();

        vecs.push_back('{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2});
        vecs.push_back('{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 2});
        vecs.push_back('{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 2});
        vecs.push_back('{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 2});
        vecs.push_back('{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2});
        vecs.push_back('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2});
        vecs.push_back('{3'd0, 32'h0000_0003, 32'hFFFF_FFFB, 32'hFFFF_FFF1, 2});
        vecs.push_back('{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2});
        vecs.push_back('{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34});
        vecs.push_back('{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34});
        vecs.push_back('{3'd5, 32'd100,       32'd7,         32'd14,        34});
        vecs.push_back('{3'd7, 32'd100,       32'd7,         32'd2,         34});
        vecs.push_back('{3'd4, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34});
        vecs.push_back('{3'd6, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 34});
        vecs.push_back('{3'd4, 32'hFFFF_FFF8, 32'hFFFF_FFFE, 32'h0000_0004, 34});
        vecs.push_back('{3'd4, 32'h8000_0000, 32'h0000_0003, 32'hD555_5556, 34});
        vecs.push_back('{3'd6, 32'h8000_0000, 32'h0000_0003, 32'hFFFF_FFFE, 34});
        vecs.push_back('{3'd5, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 34});
        vecs.push_back('{3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34});
        vecs.push_back('{3'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34});
        vecs.push_back('{3'd5, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1});
        vecs.push_back('{3'd6, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1});
        vecs.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1});
        vecs.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1});
        vecs.push_back('{3'd4, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1});
        vecs.push_back('{3'd7, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 1});

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, TAG_W'(i), vecs[i].exp, 1'b1);
            checkOutput($sformatf("vec%0d", i), vecs[i].lat);
        end

        for (int k = 0; k < 12; k++) begin
            rop  = 3'($urandom_range(0, 7));
            ra   = $urandom;
            rb   = (k % 4 == 3) ? 32'h0 : ($urandom >> $urandom_range(0, 28));
            rexp = refModel(rop, ra, rb);
            if (!rop[2]) rlat = 2;
            else if (rb == 0 || (!rop[0] && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF)) rlat = 1;
            else rlat = 34;
            applyStimulus(rop, ra, rb, TAG_W'(k + 1), rexp, 1'b1);
            checkOutput($sformatf("rand%0d_op%0d", k, rop), rlat);
        end

        // A request coinciding with flush must be dropped.
        in_op = 3'd0; in_rs1 = 32'd2; in_rs2 = 32'd3; in_tag = 5'd2;
        in_valid = 1'b1; flush = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0;
        checkVal("flush_vs_accept_in_ready", {31'b0, in_ready}, 32'd1);
        repeat (3) step();
        checkVal("flush_vs_accept_no_valid", {31'b0, out_valid}, 32'd0);

        // Backpressure: result held while out_ready is low, then back-to-back accept.
        applyStimulus(3'd0, 32'd7, 32'd6, 5'd3, 32'd42, 1'b1);
        w = 0;
        while (!out_valid && w < 100) begin
            step();
            w++;
        end
        checkVal("bp_latency", cyc - t_acc, 32'd2);
        in_op = 3'd5; in_rs1 = 32'd9; in_rs2 = 32'd0; in_tag = 5'd4;
        in_valid = 1'b1;
        for (int s = 0; s < 3; s++) begin
            step();
            checkVal($sformatf("bp_hold%0d_valid", s),    {31'b0, out_valid}, 32'd1);
            checkVal($sformatf("bp_hold%0d_result", s),   out_result, 32'd42);
            checkVal($sformatf("bp_hold%0d_tag", s),      {27'b0, out_tag}, 32'd3);
            checkVal($sformatf("bp_hold%0d_in_ready", s), {31'b0, in_ready}, 32'd0);
        end
        checkOutput("bp_release", -1);
        step();
        t_acc    = cyc;
        in_valid = 1'b0;
        sb_q.push_back('{5'd4, 32'hFFFF_FFFF});
        checkVal("bp_b2b_accepted", {31'b0, in_ready}, 32'd0);
        checkOutput("bp_b2b", 1);

        // Flush a divide ten cycles after acceptance.
        applyStimulus(3'd4, 32'd100, 32'd3, 5'd9, 32'd33, 1'b0);
        repeat (10) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        checkVal("flush_div_in_ready", {31'b0, in_ready}, 32'd1);
        seen = 1'b0;
        for (int s = 0; s < 40; s++) begin
            if (out_valid) seen = 1'b1;
            step();
        end
        checkVal("flush_div_never_valid", {31'b0, seen}, 32'd0);

        applyStimulus(3'd0, 32'd6, 32'd7, 5'd11, 32'd42, 1'b1);
        checkOutput("post_flush_mul", 2);

        // Reset while a multiply is in flight.
        applyStimulus(3'd0, 32'd5, 32'd5, 5'd7, 32'd25, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        checkVal("mid_reset_out_valid",  {31'b0, out_valid}, 32'd0);
        checkVal("mid_reset_in_ready",   {31'b0, in_ready},  32'd1);
        checkVal("mid_reset_out_result", out_result, 32'd0);
        checkVal("mid_reset_out_tag",    {27'b0, out_tag},   32'd0);
        seen = 1'b0;
        for (int s = 0; s < 5; s++) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        checkVal("mid_reset_stays_idle", {31'b0, seen}, 32'd0);

        checkVal("scoreboard_drained", sb_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
